cpu_decode_pipe: RTL and testbench

Parametrised decode stage for the RV32I-class core: register file, write-back port, full RISC-V immediate extender and a registered decode output with valid/ready handshake.
- Sits between fetch and execute.
- Supports stall, flush and write-back bypass.
- Keeps operands of a stalled instruction coherent with write-backs that arrive during the stall.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/cpu_regfile.sv | 59 +++++
 rtl/cpu_decode_pipe.sv | 147 ++++++++++++++
 tb/tb_cpu_decode_pipe.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the decode stage: immediate format codes, instruction
// field positions and register-file sizing helpers.
package cpu_pkg;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int REG_AW  = 5;

    localparam int NREG_RV32E = 16;
    localparam int NREG_RV32I = 32;

    // x0 is hardwired and addresses beyond the implemented file do not exist.
    function automatic logic reg_exists(input logic [REG_AW-1:0] addr, input int nreg);
        return (addr != '0) && (int'(addr) < nreg);
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Architectural register file: one write port, two combinational read ports
// with x0/out-of-range handling and optional same-cycle write forwarding.
module cpu_regfile
    import cpu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic [4:0]        rd_addr_a,
    input  logic [4:0]        rd_addr_b,
    output logic [XLEN-1:0]   rd_data_a,
    output logic [XLEN-1:0]   rd_data_b
);

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs_reg [NREG];
    logic            wr_ok;

    assign wr_ok = wr_en && reg_exists(wr_addr, NREG);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_reg[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic [4:0]      addr;
        logic [XLEN-1:0] data;

        assign addr = (gi == 0) ? rd_addr_a : rd_addr_b;

        always_comb begin
            data = '0;
            if (reg_exists(addr, NREG)) begin
                if ((BYPASS != 0) && wr_ok && (wr_addr == addr)) begin
                    data = wr_data;
                end else begin
                    data = regs_reg[addr[AW-1:0]];
                end
            end
        end
    end

    assign rd_data_a = g_rd[0].data;
    assign rd_data_b = g_rd[1].data;

endmodule

// File: rtl/cpu_decode_pipe.sv
// Decode stage between fetch and execute: register read, immediate extension
// and a single registered output slot with valid/ready, stall, flush and bypass.
module cpu_decode_pipe
    import cpu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inst_valid_i,
    output logic              inst_ready_o,
    input  logic [31:0]       inst_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [2:0]        imm_ext_sel_i,
    input  logic              flush_i,
    input  logic              wb_en_i,
    input  logic [4:0]        wb_addr_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic              dec_valid_o,
    input  logic              dec_ready_i,
    output logic [XLEN-1:0]   dec_pc_o,
    output logic [4:0]        rs1_addr_o,
    output logic [4:0]        rs2_addr_o,
    output logic [4:0]        rd_addr_o,
    output logic [XLEN-1:0]   reg_a_o,
    output logic [XLEN-1:0]   reg_b_o,
    output logic [XLEN-1:0]   imm_ext_o
);

    logic            dec_valid_reg;
    logic [XLEN-1:0] pc_reg;
    logic [4:0]      rs1_reg;
    logic [4:0]      rs2_reg;
    logic [4:0]      rd_reg;
    logic [XLEN-1:0] reg_a_reg;
    logic [XLEN-1:0] reg_b_reg;
    logic [XLEN-1:0] imm_reg;

    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rf_a;
    logic [XLEN-1:0] rf_b;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_next;
    logic            accept;
    logic            stall;
    logic            wb_ok;
    logic            hold_fwd_a;
    logic            hold_fwd_b;
    logic            unused_opcode;

    assign rs1_addr      = inst_i[RS1_LSB +: REG_AW];
    assign rs2_addr      = inst_i[RS2_LSB +: REG_AW];
    assign rd_addr       = inst_i[RD_LSB  +: REG_AW];
    assign unused_opcode = ^inst_i[6:0];

    cpu_regfile #(
        .XLEN   (XLEN),
        .NREG   (NREG),
        .BYPASS (BYPASS)
    ) u_regfile (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en     (wb_en_i),
        .wr_addr   (wb_addr_i),
        .wr_data   (wb_data_i),
        .rd_addr_a (rs1_addr),
        .rd_addr_b (rs2_addr),
        .rd_data_a (rf_a),
        .rd_data_b (rf_b)
    );

    always_comb begin
        imm32 = '0;
        case (imm_ext_sel_i)
            IMM_I:   imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            IMM_S:   imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            IMM_B:   imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                              inst_i[11:8], 1'b0};
            IMM_U:   imm32 = {inst_i[31:12], 12'b0};
            IMM_J:   imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                              inst_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm_next = XLEN'($signed(imm32));
    end

    assign inst_ready_o = !dec_valid_reg || dec_ready_i;
    assign accept       = inst_valid_i && inst_ready_o && !flush_i;
    assign stall        = dec_valid_reg && !dec_ready_i;
    assign wb_ok        = wb_en_i && reg_exists(wb_addr_i, NREG);

    // A stalled instruction must see write-backs that land while it waits.
    assign hold_fwd_a = (BYPASS != 0) && stall && wb_ok && (wb_addr_i == rs1_reg);
    assign hold_fwd_b = (BYPASS != 0) && stall && wb_ok && (wb_addr_i == rs2_reg);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dec_valid_reg <= 1'b0;
            pc_reg        <= '0;
            rs1_reg       <= '0;
            rs2_reg       <= '0;
            rd_reg        <= '0;
            reg_a_reg     <= '0;
            reg_b_reg     <= '0;
            imm_reg       <= '0;
        end else begin
            if (flush_i) begin
                dec_valid_reg <= 1'b0;
            end else if (accept) begin
                dec_valid_reg <= 1'b1;
            end else if (dec_ready_i) begin
                dec_valid_reg <= 1'b0;
            end

            if (accept) begin
                pc_reg    <= pc_i;
                rs1_reg   <= rs1_addr;
                rs2_reg   <= rs2_addr;
                rd_reg    <= rd_addr;
                reg_a_reg <= rf_a;
                reg_b_reg <= rf_b;
                imm_reg   <= imm_next;
            end else begin
                if (hold_fwd_a) begin
                    reg_a_reg <= wb_data_i;
                end
                if (hold_fwd_b) begin
                    reg_b_reg <= wb_data_i;
                end
            end
        end
    end

    assign dec_valid_o = dec_valid_reg;
    assign dec_pc_o    = pc_reg;
    assign rs1_addr_o  = rs1_reg;
    assign rs2_addr_o  = rs2_reg;
    assign rd_addr_o   = rd_reg;
    assign reg_a_o     = reg_a_reg;
    assign reg_b_o     = reg_b_reg;
    assign imm_ext_o   = imm_reg;

endmodule

// File: tb/tb_cpu_decode_pipe.sv
// Directed bench for cpu_decode_pipe: three instances (default, no bypass,
// RV32E-sized) share one stimulus stream; each is checked against hand values.
module tb_cpu_decode_pipe;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        inst_valid_i;
    logic [31:0] inst_i;
    logic [31:0] pc_i;
    logic [2:0]  imm_ext_sel_i;
    logic        flush_i;
    logic        wb_en_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        dec_ready_i;

    logic        rdy, vld, nb_rdy, nb_vld, e_rdy, e_vld;
    logic [31:0] pc_o, a_o, b_o, imm_o;
    logic [31:0] nb_pc, nb_a, nb_b, nb_imm;
    logic [31:0] e_pc, e_a, e_b, e_imm;
    logic [4:0]  rs1_o, rs2_o, rd_o, nb_rs1, nb_rs2, nb_rd, e_rs1, e_rs2, e_rd;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk_i = ~clk_i;

    cpu_decode_pipe #(.XLEN(32), .NREG(32), .BYPASS(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .inst_valid_i(inst_valid_i), .inst_ready_o(rdy),
        .inst_i(inst_i), .pc_i(pc_i), .imm_ext_sel_i(imm_ext_sel_i), .flush_i(flush_i),
        .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .dec_valid_o(vld), .dec_ready_i(dec_ready_i), .dec_pc_o(pc_o),
        .rs1_addr_o(rs1_o), .rs2_addr_o(rs2_o), .rd_addr_o(rd_o),
        .reg_a_o(a_o), .reg_b_o(b_o), .imm_ext_o(imm_o)
    );

    cpu_decode_pipe #(.XLEN(32), .NREG(32), .BYPASS(0)) dut_nb (
        .clk_i(clk_i), .rst_i(rst_i), .inst_valid_i(inst_valid_i), .inst_ready_o(nb_rdy),
        .inst_i(inst_i), .pc_i(pc_i), .imm_ext_sel_i(imm_ext_sel_i), .flush_i(flush_i),
        .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .dec_valid_o(nb_vld), .dec_ready_i(dec_ready_i), .dec_pc_o(nb_pc),
        .rs1_addr_o(nb_rs1), .rs2_addr_o(nb_rs2), .rd_addr_o(nb_rd),
        .reg_a_o(nb_a), .reg_b_o(nb_b), .imm_ext_o(nb_imm)
    );

    cpu_decode_pipe #(.XLEN(32), .NREG(16), .BYPASS(1)) dut_e (
        .clk_i(clk_i), .rst_i(rst_i), .inst_valid_i(inst_valid_i), .inst_ready_o(e_rdy),
        .inst_i(inst_i), .pc_i(pc_i), .imm_ext_sel_i(imm_ext_sel_i), .flush_i(flush_i),
        .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .dec_valid_o(e_vld), .dec_ready_i(dec_ready_i), .dec_pc_o(e_pc),
        .rs1_addr_o(e_rs1), .rs2_addr_o(e_rs2), .rd_addr_o(e_rd),
        .reg_a_o(e_a), .reg_b_o(e_b), .imm_ext_o(e_imm)
    );

    typedef struct {
        logic        iv;
        logic [31:0] inst;
        logic [2:0]  sel;
        logic        wbe;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic        ev;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] eimm;
        logic [4:0]  erd;
        logic [31:0] ea_nb;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // iv inst sel wbe wba wbd | ev a b imm rd a_nobypass
        vt[0] = '{1'b0, 32'h0,        3'd0, 1'b1, 5'd5, 32'h12345678,
                  1'b0, 32'h0,        32'h0,        32'h0,        5'd0,  32'h0};
        vt[1] = '{1'b1, 32'h00528293, 3'd0, 1'b0, 5'd0, 32'h0,
                  1'b1, 32'h12345678, 32'h12345678, 32'h00000005, 5'd5,  32'h12345678};
        vt[2] = '{1'b1, 32'hFFF00093, 3'd0, 1'b0, 5'd0, 32'h0,
                  1'b1, 32'h0,        32'h0,        32'hFFFFFFFF, 5'd1,  32'h0};
        vt[3] = '{1'b1, 32'hFE000EE3, 3'd2, 1'b0, 5'd0, 32'h0,
                  1'b1, 32'h0,        32'h0,        32'hFFFFFFFC, 5'd29, 32'h0};
        vt[4] = '{1'b1, 32'hFE000EE3, 3'd1, 1'b0, 5'd0, 32'h0,
                  1'b1, 32'h0,        32'h0,        32'hFFFFFFFD, 5'd29, 32'h0};
        vt[5] = '{1'b1, 32'h123450B7, 3'd3, 1'b0, 5'd0, 32'h0,
                  1'b1, 32'h0,        32'h0,        32'h12345000, 5'd1,  32'h0};
        vt[6] = '{1'b1, 32'h123450B7, 3'd4, 1'b0, 5'd0, 32'h0,
                  1'b1, 32'h0,        32'h0,        32'h00045922, 5'd1,  32'h0};
        vt[7] = '{1'b1, 32'h123450B7, 3'd5, 1'b0, 5'd0, 32'h0,
                  1'b1, 32'h0,        32'h0,        32'h00000000, 5'd1,  32'h0};
        vt[8] = '{1'b1, 32'h00528293, 3'd0, 1'b1, 5'd5, 32'hDEADBEEF,
                  1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000005, 5'd5,  32'h12345678};
        vt[9] = '{1'b1, 32'hFFF00093, 3'd0, 1'b1, 5'd0, 32'hFFFFFFFF,
                  1'b1, 32'h0,        32'h0,        32'hFFFFFFFF, 5'd1,  32'h0};

        rst_i = 1'b1;
        inst_valid_i = 1'b0; inst_i = '0; pc_i = '0; imm_ext_sel_i = '0;
        flush_i = 1'b0; wb_en_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
        dec_ready_i = 1'b1;
        #2;
        chk("reset_valid", {31'b0, vld}, 32'h0);
        chk("reset_a", a_o, 32'h0);
        chk("reset_imm", imm_o, 32'h0);
        chk("reset_pc", pc_o, 32'h0);
        chk("reset_ready", {31'b0, rdy}, 32'h1);
        tick();
        rst_i = 1'b0;

        for (int i = 0; i < 10; i++) begin
            inst_valid_i = vt[i].iv; inst_i = vt[i].inst; imm_ext_sel_i = vt[i].sel;
            pc_i = 32'h1000 + 32'(i) * 4;
            wb_en_i = vt[i].wbe; wb_addr_i = vt[i].wba; wb_data_i = vt[i].wbd;
            dec_ready_i = 1'b1;
            tick();
            $display("vec %0d: valid=%b a=%h b=%h imm=%h rd=%0d a_nb=%h", i, vld, a_o, b_o,
                     imm_o, rd_o, nb_a);
            chk($sformatf("v%0d_valid", i), {31'b0, vld}, {31'b0, vt[i].ev});
            chk($sformatf("v%0d_a", i), a_o, vt[i].ea);
            chk($sformatf("v%0d_b", i), b_o, vt[i].eb);
            chk($sformatf("v%0d_imm", i), imm_o, vt[i].eimm);
            chk($sformatf("v%0d_rd", i), {27'b0, rd_o}, {27'b0, vt[i].erd});
            chk($sformatf("v%0d_a_nobypass", i), nb_a, vt[i].ea_nb);
            chk($sformatf("v%0d_a_rv32e", i), e_a, vt[i].ea);
            if (vt[i].ev) chk($sformatf("v%0d_pc", i), pc_o, 32'h1000 + 32'(i) * 4);
        end

        // drain while writing x7
        inst_valid_i = 1'b0; wb_en_i = 1'b1; wb_addr_i = 5'd7; wb_data_i = 32'h11111111;
        tick();
        $display("drain: valid=%b", vld);
        chk("drain_valid", {31'b0, vld}, 32'h0);

        // add x3,x5,x7
        inst_valid_i = 1'b1; inst_i = 32'h007281B3; imm_ext_sel_i = 3'd0; pc_i = 32'h2000;
        wb_en_i = 1'b0;
        tick();
        $display("add accept: a=%h b=%h imm=%h", a_o, b_o, imm_o);
        chk("add_a", a_o, 32'hDEADBEEF);
        chk("add_b", b_o, 32'h11111111);
        chk("add_rs2", {27'b0, rs2_o}, 32'd7);

        // 3-cycle stall with a new instruction pending; wb to held rs2 in the middle
        inst_i = 32'hFFF00093; pc_i = 32'h2004; dec_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wb_en_i = (k == 1); wb_addr_i = 5'd7; wb_data_i = 32'hA5A5A5A5;
            #1;
            chk($sformatf("stall%0d_ready", k), {31'b0, rdy}, 32'h0);
            tick();
            $display("stall %0d: valid=%b a=%h b=%h b_nb=%h", k, vld, a_o, b_o, nb_b);
            chk($sformatf("stall%0d_valid", k), {31'b0, vld}, 32'h1);
            chk($sformatf("stall%0d_pc", k), pc_o, 32'h2000);
            chk($sformatf("stall%0d_imm", k), imm_o, 32'h7);
            chk($sformatf("stall%0d_rd", k), {27'b0, rd_o}, 32'd3);
            chk($sformatf("stall%0d_a", k), a_o, 32'hDEADBEEF);
            chk($sformatf("stall%0d_b", k), b_o, (k >= 1) ? 32'hA5A5A5A5 : 32'h11111111);
            chk($sformatf("stall%0d_b_nobypass", k), nb_b, 32'h11111111);
        end
        inst_valid_i = 1'b0; wb_en_i = 1'b0; dec_ready_i = 1'b1;
        tick();
        chk("stall_drain_valid", {31'b0, vld}, 32'h0);

        // flush beats accept; concurrent write-back to x9 still commits
        inst_valid_i = 1'b1; inst_i = 32'h00048013; pc_i = 32'h3000; flush_i = 1'b1;
        wb_en_i = 1'b1; wb_addr_i = 5'd9; wb_data_i = 32'h00000099;
        tick();
        $display("flush accept: valid=%b", vld);
        chk("flush_valid", {31'b0, vld}, 32'h0);
        flush_i = 1'b0; wb_en_i = 1'b0;
        tick();
        $display("after flush: valid=%b a=%h a_nb=%h", vld, a_o, nb_a);
        chk("postflush_valid", {31'b0, vld}, 32'h1);
        chk("postflush_a", a_o, 32'h99);
        chk("postflush_a_nobypass", nb_a, 32'h99);

        // flush of a held instruction; ready still reflects the stall
        dec_ready_i = 1'b0; flush_i = 1'b1;
        #1;
        chk("flush_hold_ready", {31'b0, rdy}, 32'h0);
        tick();
        chk("flush_hold_valid", {31'b0, vld}, 32'h0);
        flush_i = 1'b0; inst_valid_i = 1'b0; dec_ready_i = 1'b1;

        // x20 exists only in the 32-entry file
        wb_en_i = 1'b1; wb_addr_i = 5'd20; wb_data_i = 32'h20202020;
        tick();
        wb_en_i = 1'b0; inst_valid_i = 1'b1; inst_i = 32'h000A0013; pc_i = 32'h4000;
        tick();
        $display("x20 read: a=%h a_rv32e=%h", a_o, e_a);
        chk("x20_a", a_o, 32'h20202020);
        chk("x20_a_rv32e", e_a, 32'h0);
        chk("x20_valid_rv32e", {31'b0, e_vld}, 32'h1);

        // asynchronous reset while an instruction is held
        inst_valid_i = 1'b0; dec_ready_i = 1'b0;
        #3;
        rst_i = 1'b1;
        #1;
        $display("async reset: valid=%b a=%h", vld, a_o);
        chk("arst_valid", {31'b0, vld}, 32'h0);
        chk("arst_a", a_o, 32'h0);
        chk("arst_valid_rv32e", {31'b0, e_vld}, 32'h0);
        #2;
        rst_i = 1'b0;
        tick();
        inst_valid_i = 1'b1; inst_i = 32'h007281B3; pc_i = 32'h5000; dec_ready_i = 1'b1;
        tick();
        $display("post reset read: valid=%b a=%h b=%h", vld, a_o, b_o);
        chk("prst_valid", {31'b0, vld}, 32'h1);
        chk("prst_a", a_o, 32'h0);
        chk("prst_b", b_o, 32'h0);
        chk("prst_imm", imm_o, 32'h7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
